// File: rtl/raymarch_frame_scheduler_if.sv
// Raymarcher issue/return channel and frame-buffer write channel of the frame scheduler.
interface raymarch_frame_scheduler_if #(
  parameter int ADDR_W = 19
);
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;
  logic              pix_valid;
  logic [23:0]       rm_rgb;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_data;
  logic              fb_valid;
  logic              fb_ready;

  modport master (
    output pix_x, pix_y, pix_valid, fb_addr, fb_data, fb_valid,
    input  rm_rgb, fb_ready
  );

  modport slave (
    input  pix_x, pix_y, pix_valid, fb_addr, fb_data, fb_valid,
    output rm_rgb, fb_ready
  );
endinterface

// File: rtl/raymarch_frame_scheduler.sv
// Credit-based frame scheduler feeding a fixed-latency raymarcher and draining results to a frame buffer.
// Define RAYMARCH_SCHED_PERF_EN to add the frame_cycles busy-cycle counter output.
module raymarch_frame_scheduler #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PIPE_LATENCY  = 100,
  parameter int FIFO_DEPTH    = 128,
  parameter int ADDR_W        = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
`ifdef RAYMARCH_SCHED_PERF_EN
  output logic [31:0] frame_cycles,
`endif
  raymarch_frame_scheduler_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PW    = PTR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0] X_LAST = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [9:0]              x_q, x_d;
  logic [9:0]              y_q, y_d;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic [PIPE_LATENCY-1:0] valid_dl_q, valid_dl_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]       fb_addr_q, fb_addr_d;
  logic                    frame_done_q, frame_done_d;
  logic [23:0]             fifo_mem [FIFO_DEPTH];

  logic issue, push, pop, fifo_empty, last_pix;

  // Credits cover both in-flight samples and FIFO contents, so a push can never find the FIFO full.
  assign issue      = (state_q == S_RUN) && (outstanding_q < CNT_W'(FIFO_DEPTH));
  assign push       = valid_dl_q[PIPE_LATENCY-1];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign pop        = !fifo_empty && bus.fb_ready;
  assign last_pix   = (x_q == X_LAST) && (y_q == Y_LAST);

  assign busy          = (state_q != S_IDLE);
  assign frame_done    = frame_done_q;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.pix_valid = issue;
  assign bus.fb_addr   = fb_addr_q;
  assign bus.fb_data   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign bus.fb_valid  = !fifo_empty;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    outstanding_d = outstanding_q;
    valid_dl_d    = (valid_dl_q << 1) | PIPE_LATENCY'(issue);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    fb_addr_d     = fb_addr_q + ADDR_W'(pop);
    frame_done_d  = 1'b0;

    case ({issue, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (issue) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = last_pix ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d   = S_RUN;
          x_d       = '0;
          y_d       = '0;
          fb_addr_d = '0;
        end
      end
      S_RUN: begin
        if (issue && last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave as the final write completes so frame_done lines up with the first idle cycle.
        if (outstanding_d == '0) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      outstanding_q <= '0;
      valid_dl_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fb_addr_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      outstanding_q <= outstanding_d;
      valid_dl_q    <= valid_dl_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fb_addr_q     <= fb_addr_d;
      frame_done_q  <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.rm_rgb;
  end

`ifdef RAYMARCH_SCHED_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (state_q == S_IDLE && frame_start) begin
      cycles_d = '0;
    end else if (busy && cycles_q != 32'hFFFF_FFFF) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end

  assign frame_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Scoreboard bench for raymarch_frame_scheduler on a 4x3 frame, latency 5, FIFO depth 8.
module tb_raymarch_frame_scheduler;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int L  = 5;
  localparam int D  = 8;
  localparam int AW = 4;

  logic clk;
  logic rst_n;
  logic frame_start;
  logic busy;
  logic frame_done;
`ifdef RAYMARCH_SCHED_PERF_EN
  logic [31:0] frame_cycles;
`endif

  raymarch_frame_scheduler_if #(.ADDR_W(AW)) bus ();

  raymarch_frame_scheduler #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .PIPE_LATENCY (L),
    .FIFO_DEPTH   (D),
    .ADDR_W       (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_done  (frame_done),
`ifdef RAYMARCH_SCHED_PERF_EN
    .frame_cycles(frame_cycles),
`endif
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [23:0] rgb_of(input logic [9:0] x, input logic [9:0] y);
    return {x[7:0], y[7:0], 8'hA5};
  endfunction

  // Model raymarcher: pure delay line of the colour computed from the issued coordinates.
  logic [23:0] rm_pipe [L];
  always @(posedge clk) begin
    rm_pipe[0] <= rgb_of(bus.pix_x, bus.pix_y);
    for (int i = 1; i < L; i++) rm_pipe[i] <= rm_pipe[i-1];
  end
  assign bus.rm_rgb = rm_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] sb [$];
  int          issues = 0, writes = 0, done_count = 0, busy_cycles = 0, dup_count = 0;
  int          first_issue_cyc = -1, last_issue_cyc = -1, exp_idx = 0, start_cyc = 0;
  logic [9:0]  exp_x = '0, exp_y = '0;
  logic [15:0] written_mask = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (busy) busy_cycles++;
      if (frame_done) done_count++;
      if (frame_start && !busy) begin
        exp_x = '0; exp_y = '0; exp_idx = 0; issues = 0; writes = 0; busy_cycles = 0;
        dup_count = 0; written_mask = '0; first_issue_cyc = -1; last_issue_cyc = -1;
      end
      if (bus.pix_valid) begin
        check_eq("pix_x", 32'(bus.pix_x), 32'(exp_x));
        check_eq("pix_y", 32'(bus.pix_y), 32'(exp_y));
        sb.push_back({16'(exp_idx), rgb_of(exp_x, exp_y)});
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        issues++;
        exp_idx++;
        if (exp_x == 10'(W - 1)) begin
          exp_x = '0;
          exp_y = exp_y + 10'd1;
        end else begin
          exp_x = exp_x + 10'd1;
        end
      end
      if (bus.fb_valid && bus.fb_ready) begin
        $display("[%0d] fb write addr=%0d data=%06h", cyc, bus.fb_addr, bus.fb_data);
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'(bus.fb_addr), 32'hFFFF_FFFF);
        end else begin
          logic [39:0] e;
          e = sb.pop_front();
          check_eq("fb_addr", 32'(bus.fb_addr), 32'(e[39:24]));
          check_eq("fb_data", 32'(bus.fb_data), 32'(e[23:0]));
        end
        if (written_mask[bus.fb_addr]) dup_count++;
        written_mask[bus.fb_addr] = 1'b1;
        writes++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    start_cyc   = cyc;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int d0 = done_count;
    int n  = 0;
    while (done_count == d0 && n < max_cycles) begin
      step();
      n++;
    end
    check_eq(tag, 32'(done_count != d0), 32'd1);
  endtask

  task automatic check_full_frame(input string tag);
    check_eq({tag, "_issues"}, 32'(issues), 32'd12);
    check_eq({tag, "_writes"}, 32'(writes), 32'd12);
    check_eq({tag, "_mask"}, 32'(written_mask), 32'h0FFF);
    check_eq({tag, "_dups"}, 32'(dup_count), 32'd0);
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_before;
    int got;
    rst_n        = 1'b0;
    frame_start  = 1'b0;
    bus.fb_ready = 1'b0;

    // Test 1: reset values
    step(2);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check_eq("rst_fb_valid", 32'(bus.fb_valid), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Test 2: free-flowing frame
    bus.fb_ready = 1'b1;
    d_before = done_count;
    start_frame();
    wait_done("t2_done", 200);
    check_eq("t2_busy_after", 32'(busy), 32'd0);
    step(5);
    check_full_frame("t2");
    check_eq("t2_first_issue", 32'(first_issue_cyc), 32'(start_cyc + 1));
    check_eq("t2_last_issue", 32'(last_issue_cyc), 32'(start_cyc + 12));
    check_eq("t2_done_once", 32'(done_count - d_before), 32'd1);
`ifdef RAYMARCH_SCHED_PERF_EN
    check_eq("t6_cycles", frame_cycles, 32'(busy_cycles));
    step(5);
    check_eq("t6_cycles_hold", frame_cycles, 32'(busy_cycles));
`endif

    // Test 3: full back-pressure, credits stop issue at FIFO_DEPTH
    bus.fb_ready = 1'b0;
    start_frame();
    step(40);
    check_eq("t3_issues_stalled", 32'(issues), 32'(D));
    check_eq("t3_pix_valid_low", 32'(bus.pix_valid), 32'd0);
    check_eq("t3_fb_valid", 32'(bus.fb_valid), 32'd1);
    check_eq("t3_no_writes", 32'(writes), 32'd0);
    check_eq("t3_busy", 32'(busy), 32'd1);
    bus.fb_ready = 1'b1;
    wait_done("t3_done", 200);
    step(3);
    check_full_frame("t3");

    // Test 4: ignored start during RUN, random back-pressure, restart in the frame_done cycle
    start_frame();
    step(3);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      bus.fb_ready = 1'($urandom_range(0, 1));
      if (frame_done) begin
        got = 1;
        check_eq("t4_idle_in_done", 32'(busy), 32'd0);
        check_full_frame("t4a");
        frame_start = 1'b1;
        start_cyc   = cyc;
        step();
        frame_start = 1'b0;
        check_eq("t4_restart_busy", 32'(busy), 32'd1);
        check_eq("t4_restart_addr", 32'(bus.fb_addr), 32'd0);
      end else begin
        step();
      end
    end
    check_eq("t4_done_seen", 32'(got), 32'd1);
    bus.fb_ready = 1'b1;
    wait_done("t4b_done", 200);
    step(3);
    check_full_frame("t4b");

    // Test 5: reset mid-frame discards in-flight results
    start_frame();
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      if (issues >= 6) got = 1;
      else step();
    end
    check_eq("t5_six_issues", 32'(issues), 32'd6);
    rst_n = 1'b0;
    step();
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_frame_done", 32'(frame_done), 32'd0);
    check_eq("t5_pix_valid", 32'(bus.pix_valid), 32'd0);
    check_eq("t5_fb_valid", 32'(bus.fb_valid), 32'd0);
    check_eq("t5_pix_x", 32'(bus.pix_x), 32'd0);
    check_eq("t5_pix_y", 32'(bus.pix_y), 32'd0);
    check_eq("t5_fb_addr", 32'(bus.fb_addr), 32'd0);
    rst_n = 1'b1;
    got = writes;
    step(15);
    check_eq("t5_no_stale_writes", 32'(writes), 32'(got));
    check_eq("t5_fb_valid_idle", 32'(bus.fb_valid), 32'd0);
    start_frame();
    wait_done("t5_done", 200);
    step(3);
    check_full_frame("t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
